// File: rtl/tmr_scrub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tmr_scrub_ctrl                                                |
// | Purpose  : Scrub controller for a bank of triplicated registers. Walks   |
// |            every word, reads the three copies, votes bit-wise and (when  |
// |            writeback is compiled in) rewrites all copies with the voted  |
// |            value if any copy disagrees. Counts upset words.              |
// | Macro    : SCRUB_WRITEBACK_EN - defined: WRITE state corrects words;     |
// |            undefined: detect-only, wr_en/wr_addr/wr_data tied to 0.      |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            start      - begin a pass at address 0 when idle              |
// |            continuous - wrap to address 0 at end of pass                 |
// |            rd_addr    - bank read address, data returns next cycle       |
// |            rd_a/b/c   - copy A/B/C read data                             |
// |            wr_en/wr_addr/wr_data - write port to all three copies        |
// |            busy, done - pass in progress / end-of-pass pulse             |
// |            err_cnt    - saturating count of mismatched words             |
// |            err_addr   - address of most recent mismatched word           |
// |            err_clr    - clears err_cnt                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tmr_scrub_ctrl #(
  parameter int N_WORDS = 16,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16,
  localparam int AW     = $clog2(N_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_a,
  input  logic [WIDTH-1:0] rd_b,
  input  logic [WIDTH-1:0] rd_c,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [AW-1:0]    err_addr,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CHECK = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam logic [AW-1:0]    c_LAST    = AW'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [AW-1:0]     err_addr_q, err_addr_d;
  logic              w_mismatch;
  logic              w_advance;

  // Any disagreement among the copies; b != c is implied by these two tests.
  assign w_mismatch = (rd_a != rd_b) || (rd_a != rd_c);

`ifdef SCRUB_WRITEBACK_EN
  logic [WIDTH-1:0] voted_q, voted_d;
  logic [WIDTH-1:0] w_voted;

  assign w_voted = (rd_a & rd_b) | (rd_a & rd_c) | (rd_b & rd_c);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    w_advance  = 1'b0;
`ifdef SCRUB_WRITEBACK_EN
    voted_d    = voted_q;
`endif

    // A clear coinciding with an increment is overridden below to 1.
    if (err_clr) begin
      err_cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
`ifdef SCRUB_WRITEBACK_EN
        voted_d = w_voted;
`endif
        if (w_mismatch) begin
          err_addr_d = addr_q;
          if (err_clr) begin
            err_cnt_d = CNT_W'(1);
          end else if (err_cnt_q != c_CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
`ifdef SCRUB_WRITEBACK_EN
          state_d = S_WRITE;
`else
          w_advance = 1'b1;
`endif
        end else begin
          w_advance = 1'b1;
        end
      end
      S_WRITE: begin
        w_advance = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_advance) begin
      if (addr_q != c_LAST) begin
        addr_d  = addr_q + AW'(1);
        state_d = S_READ;
      end else begin
        done_d  = 1'b1;
        addr_d  = '0;
        state_d = continuous ? S_READ : S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

`ifdef SCRUB_WRITEBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      voted_q <= '0;
    end else begin
      voted_q <= voted_d;
    end
  end

  // WRITE always exits after one cycle, so wr_en can never be back-to-back.
  assign wr_en   = (state_q == S_WRITE);
  assign wr_addr = (state_q == S_WRITE) ? addr_q : '0;
  assign wr_data = (state_q == S_WRITE) ? voted_q : '0;
`else
  assign wr_en   = 1'b0;
  assign wr_addr = '0;
  assign wr_data = '0;
`endif

  assign rd_addr  = (state_q == S_IDLE) ? '0 : addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

endmodule
`default_nettype wire
